modulus_chunk_sequencer: RTL

- Sequences the upper bits of a double-width square result through the 30-bit modulus chunk LUT, one BIT_LEN chunk at a time.
- Drives the LUT's address, clock-enable and bypass controls.
- Tags each resulting set of moduli terms with an index and last flag for the downstream accumulator.
- Signals completion once the accumulator pipeline has drained.

---
 rtl/modulus_chunk_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/modulus_chunk_sequencer.sv
// Walks the upper half of a double-width square through the modulus chunk LUT one
// BIT_LEN chunk per accepted issue, tagging terms and pulsing done once the accumulator drains.
module modulus_chunk_sequencer #(
    parameter int MODULUS_WIDTH = 1024,
    parameter int BIT_LEN       = 30,
    parameter int NUM_CHUNKS    = 4,
    parameter int ACC_LAT       = 2,
    localparam int IDX_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [NUM_CHUNKS*BIT_LEN-1:0] upper_bits,
    input  logic                          cfg_bypass,
    input  logic                          acc_ready,
    output logic [BIT_LEN-1:0]            lut_addr,
    output logic                          lut_ce,
    output logic                          lut_bypass,
    output logic                          term_valid,
    output logic [IDX_W-1:0]              term_idx,
    output logic                          term_last,
    output logic                          busy,
    output logic                          done
);

    localparam int CHUNK_W = NUM_CHUNKS * BIT_LEN;
    localparam int CNT_W   = $clog2(ACC_LAT + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    // Bypass mode already showed term_last in the final issue cycle; registered mode shows it one cycle into DRAIN.
    localparam logic [CNT_W-1:0] CNT_BYP  = CNT_W'((ACC_LAT > 0) ? ACC_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_REGM = CNT_W'(ACC_LAT);

    generate
        if (MODULUS_WIDTH < 1 || BIT_LEN < 1 || NUM_CHUNKS < 1 || ACC_LAT < 0) begin : g_bad_params
            $error("modulus_chunk_sequencer: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [CHUNK_W-1:0]   chunk_reg, chunk_next, chunk_shifted;
    logic                 byp_reg, byp_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 pend_reg, pend_next;
    logic [IDX_W-1:0]     pend_idx_reg, pend_idx_next;
    logic                 start_ready_reg, start_ready_next;
    logic                 issue_term;

    generate
        if (NUM_CHUNKS > 1) begin : g_shift
            assign chunk_shifted = {{BIT_LEN{1'b0}}, chunk_reg[CHUNK_W-1:BIT_LEN]};
        end else begin : g_single
            assign chunk_shifted = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            chunk_reg       <= '0;
            byp_reg         <= 1'b0;
            idx_reg         <= '0;
            cnt_reg         <= '0;
            pend_reg        <= 1'b0;
            pend_idx_reg    <= '0;
            start_ready_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            chunk_reg       <= chunk_next;
            byp_reg         <= byp_next;
            idx_reg         <= idx_next;
            cnt_reg         <= cnt_next;
            pend_reg        <= pend_next;
            pend_idx_reg    <= pend_idx_next;
            start_ready_reg <= start_ready_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        chunk_next    = chunk_reg;
        byp_next      = byp_reg;
        idx_next      = idx_reg;
        cnt_next      = cnt_reg;
        pend_next     = 1'b0;
        pend_idx_next = pend_idx_reg;
        case (state_reg)
            IDLE: begin
                if (start_valid && start_ready_reg) begin
                    chunk_next = upper_bits;
                    byp_next   = cfg_bypass;
                    idx_next   = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (acc_ready) begin
                    chunk_next    = chunk_shifted;
                    idx_next      = idx_reg + IDX_W'(1);
                    pend_next     = !byp_reg;
                    pend_idx_next = idx_reg;
                    if (idx_reg == LAST_IDX) begin
                        if (byp_reg && ACC_LAT == 0) begin
                            state_next = DONE;
                        end else begin
                            state_next = DRAIN;
                            cnt_next   = byp_reg ? CNT_BYP : CNT_REGM;
                        end
                    end
                end
            end
            DRAIN: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Registered from the next state so ready reappears the cycle right after DONE.
        start_ready_next = (state_next == IDLE);
    end

    assign start_ready = start_ready_reg;
    assign lut_addr    = chunk_reg[BIT_LEN-1:0];
    assign lut_ce      = (state_reg == ISSUE) && acc_ready;
    assign lut_bypass  = byp_reg;
    assign issue_term  = byp_reg && lut_ce;
    assign term_valid  = issue_term || pend_reg;
    assign term_idx    = pend_reg ? pend_idx_reg : (issue_term ? idx_reg : '0);
    assign term_last   = term_valid && (term_idx == LAST_IDX);
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);

endmodule
